keccak_padder_gen: RTL and testbench

Parametrised successor to the fixed 32-bit/576-bit Keccak padder. Accepts a message as a stream of IN_W-bit words with byte_num/is_last framing, applies Keccak (0x01) or SHA-3 (0x06) multi-rate padding, and assembles rate-sized blocks for the permutation core. Rate is selectable at run time across SHA3-224/256/384/512. Sits between the host word interface and the f_permutation block inside the keccak top.

---
 rtl/keccak_pkg.sv | 36 +++
 rtl/keccak_pad_word.sv | 35 +++
 rtl/keccak_padder_gen.sv | 168 ++++++++++++++++
 tb/tb_keccak_padder_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_pkg
//  Purpose  : Shared definitions for the parametrised Keccak padder: rate
//             select encoding, rate lookup, pad byte values and FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    // Rate select encoding carried on the mode input.
    localparam logic [1:0] MODE_1152 = 2'd0;
    localparam logic [1:0] MODE_1088 = 2'd1;
    localparam logic [1:0] MODE_832  = 2'd2;
    localparam logic [1:0] MODE_576  = 2'd3;

    // Rate in bits, indexed by mode.
    localparam int RATE_BITS [4] = '{1152, 1088, 832, 576};

    localparam logic [7:0] PAD_KECCAK = 8'h01;
    localparam logic [7:0] PAD_SHA3   = 8'h06;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of input words that make up one rate-sized block.
    function automatic int words_per_block(input logic [1:0] mode, input int in_w);
        return RATE_BITS[mode] / in_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_pad_word.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_pad_word
//  Purpose  : Builds the padded final message word. Bytes 0..byte_num-1 are
//             taken from in, byte byte_num receives pad_byte and every later
//             byte is zero. Byte 0 lives in the MSB lane.
//  Ports    : in       - final message word (IN_W bits)
//             byte_num - count of valid message bytes in the word
//             pad_byte - first pad byte (0x01 Keccak / 0x06 SHA-3)
//             out      - padded word
//  Revision : 1.0 - initial release
// ============================================================================
module keccak_pad_word #(
    parameter int IN_W = 32,
    parameter int BN_W = $clog2(IN_W / 8)
) (
    input  logic [IN_W-1:0] in,
    input  logic [BN_W-1:0] byte_num,
    input  logic [7:0]      pad_byte,
    output logic [IN_W-1:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < IN_W / 8; i++) begin
            if (i < int'(byte_num)) begin
                out[IN_W-1-8*i -: 8] = in[IN_W-1-8*i -: 8];
            end else if (i == int'(byte_num)) begin
                out[IN_W-1-8*i -: 8] = pad_byte;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/keccak_padder_gen.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_padder_gen
//  Purpose  : Collects IN_W-bit message words into rate-sized blocks, applies
//             Keccak/SHA-3 multi-rate padding to the final block and hands
//             each block to the permutation core with a full/ack handshake.
//  Ports    : clk, reset (async, active-low)
//             mode        - rate select 0=1152 1=1088 2=832 3=576 bits
//             sha3_pad    - first pad byte 0x06 when set, else 0x01
//             in/in_ready - message word and its valid strobe
//             is_last     - word is the final one of the message
//             byte_num    - valid bytes in the final word
//             buffer_full - out holds a complete block
//             out         - block, byte 0 at MSBs, left-aligned
//             out_last    - block is the final block of the message
//             f_ack       - core has consumed the block
//  Revision : 1.0 - initial release
// ============================================================================
module keccak_padder_gen
    import keccak_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int MAX_RATE = 1152,
    parameter int BN_W     = $clog2(IN_W / 8)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic                sha3_pad,
    input  logic [IN_W-1:0]     in,
    input  logic                in_ready,
    input  logic                is_last,
    input  logic [BN_W-1:0]     byte_num,
    output logic                buffer_full,
    output logic [MAX_RATE-1:0] out,
    output logic                out_last,
    input  logic                f_ack
);

    localparam int SLOT_W = $clog2(MAX_RATE / IN_W);

    state_t              state, state_nxt;
    logic [SLOT_W-1:0]   slot;
    logic [1:0]          mode_q;
    logic                sha3_q;
    logic [MAX_RATE-1:0] block;
    logic                full_q;
    logic                last_q;

    logic [1:0]          cur_mode;
    logic                cur_sha3;
    logic [7:0]          pad_byte;
    logic [IN_W-1:0]     padded;
    logic [SLOT_W-1:0]   last_slot;
    logic                accept;
    logic                pad_fill;
    logic                write;
    logic                at_end;
    logic                final_blk;
    logic [IN_W-1:0]     wdata;

    // The first word of a message is written before mode/sha3_pad are
    // latched, so it sees the live inputs; every later word uses the copy.
    assign cur_mode = (state == IDLE) ? mode : mode_q;
    assign cur_sha3 = (state == IDLE) ? sha3_pad : sha3_q;
    assign pad_byte = cur_sha3 ? PAD_SHA3 : PAD_KECCAK;

    keccak_pad_word #(
        .IN_W (IN_W),
        .BN_W (BN_W)
    ) u_pad_word (
        .in       (in),
        .byte_num (byte_num),
        .pad_byte (pad_byte),
        .out      (padded)
    );

    always_comb begin
        last_slot = SLOT_W'(words_per_block(cur_mode, IN_W) - 1);
        accept    = in_ready && !full_q && ((state == IDLE) || (state == FILL));
        pad_fill  = (state == PAD);
        write     = accept || pad_fill;
        at_end    = (slot == last_slot);
        final_blk = pad_fill || (accept && is_last);

        if (pad_fill) begin
            wdata = '0;
        end else if (is_last) begin
            wdata = padded;
        end else begin
            wdata = in;
        end
        // The closing 0x80 belongs to the final block only; it lands in the
        // least significant byte of the last slot and may merge with the
        // first pad byte (0x81 / 0x86).
        if (at_end && final_blk) begin
            wdata[7:0] = wdata[7:0] | PAD_END;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FILL: begin
                if (accept) begin
                    if (is_last) begin
                        state_nxt = at_end ? DONE : PAD;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            PAD: begin
                if (at_end) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot   <= '0;
            mode_q <= '0;
            sha3_q <= 1'b0;
            block  <= '0;
            full_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            if (accept && (state == IDLE)) begin
                mode_q <= mode;
                sha3_q <= sha3_pad;
            end
            // accept already excludes a full buffer, so an ack and a word on
            // the same edge can never both act.
            if (full_q && f_ack) begin
                full_q <= 1'b0;
                last_q <= 1'b0;
                slot   <= '0;
            end else if (write) begin
                block[MAX_RATE-1-int'(slot)*IN_W -: IN_W] <= wdata;
                if (at_end) begin
                    full_q <= 1'b1;
                    last_q <= final_blk;
                end else begin
                    slot <= slot + 1'b1;
                end
            end
        end
    end

    assign buffer_full = full_q;
    assign out         = block;
    assign out_last    = last_q;

endmodule
`default_nettype wire

// File: tb/tb_keccak_padder_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_keccak_padder_gen
//  Purpose  : Self-checking bench for keccak_padder_gen (32- and 64-bit word
//             instances). Expected blocks are queued by the stimulus and
//             compared by an independent monitor whenever a block appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keccak_padder_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mode;
    logic         sha3_pad;
    logic [63:0]  din;
    logic         in_ready;
    logic         is_last;
    logic [2:0]   bn;
    logic         f_ack;
    logic         sel64;

    logic         bf32, bf64, ol32, ol64;
    logic [1151:0] out32, out64;
    logic         bf, ol;
    logic [1151:0] ob;

    always #5 clk = ~clk;

    keccak_padder_gen #(.IN_W(32)) dut32 (
        .clk         (clk),
        .reset       (rst_n),
        .mode        (mode),
        .sha3_pad    (sha3_pad),
        .in          (din[31:0]),
        .in_ready    (in_ready & ~sel64),
        .is_last     (is_last),
        .byte_num    (bn[1:0]),
        .buffer_full (bf32),
        .out         (out32),
        .out_last    (ol32),
        .f_ack       (f_ack & ~sel64)
    );

    keccak_padder_gen #(.IN_W(64)) dut64 (
        .clk         (clk),
        .reset       (rst_n),
        .mode        (mode),
        .sha3_pad    (sha3_pad),
        .in          (din),
        .in_ready    (in_ready & sel64),
        .is_last     (is_last),
        .byte_num    (bn),
        .buffer_full (bf64),
        .out         (out64),
        .out_last    (ol64),
        .f_ack       (f_ack & sel64)
    );

    assign bf = sel64 ? bf64 : bf32;
    assign ol = sel64 ? ol64 : ol32;
    assign ob = sel64 ? out64 : out32;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_delay = 0;

    typedef struct {
        logic [1151:0] blk;
        bit            last;
        int            rise;
    } exp_t;
    exp_t sbq[$];

    logic [1151:0] eb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cmp_blk(input string name, input logic [1151:0] act, input logic [1151:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            for (int i = 0; i < 144; i++) begin
                if (act[1151-8*i -: 8] !== exp[1151-8*i -: 8]) begin
                    $display("FAIL %s: byte %0d got %h expected %h", name, i,
                             act[1151-8*i -: 8], exp[1151-8*i -: 8]);
                    break;
                end
            end
        end
    endtask

    task automatic put_byte(input int i, input logic [7:0] v);
        eb[1151-8*i -: 8] = v;
    endtask

    task automatic push_exp(input bit last, input int rise);
        exp_t e;
        e.blk = eb; e.last = last; e.rise = rise;
        sbq.push_back(e);
    endtask

    // Monitor: compare every newly presented block against the scoreboard and
    // make sure the block does not change while it is held.
    initial begin : monitor
        bit            prev = 1'b0;
        logic [1151:0] rise_out = '0;
        logic [1151:0] held = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (bf && !prev) begin
                rise_out = ob;
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_block: got block at cycle %0d expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    cmp_blk("block_data", ob, e.blk);
                    chk("block_last", 64'(ol), 64'(e.last));
                    if (e.rise >= 0) chk("latency_cycle", 64'(cyc), 64'(e.rise));
                end
            end
            if (bf) held = ob;
            if (!bf && prev) cmp_blk("held_block_stable", held, rise_out);
            prev = bf;
        end
    end

    // Core model: acknowledge a full buffer after ack_delay cycles.
    initial begin : acker
        int wcnt = 0;
        f_ack = 1'b0;
        forever begin
            @(negedge clk);
            f_ack = 1'b0;
            if (bf) begin
                if (wcnt >= ack_delay) begin
                    f_ack = 1'b1;
                    wcnt  = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        in_ready = 1'b0; is_last = 1'b0; bn = '0; din = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [63:0] w, input bit last, input int b, output int acc);
        int t = 0;
        @(negedge clk);
        din = w; is_last = last; bn = 3'(b); in_ready = 1'b1;
        while (bf && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bf) begin
            n_checks++;
            $display("FAIL send_timeout: got buffer_full=1 after %0d cycles expected 0", t);
        end
        @(posedge clk);
        #1 acc = cyc;
    endtask

    task automatic send32(input logic [31:0] w, input bit last, input int b, output int acc);
        send({32'h0, w}, last, b, acc);
    endtask

    task automatic end_msg();
        @(negedge clk);
        in_ready = 1'b0;
        is_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || bf) && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (sbq.size() == 0 && !bf) n_pass++;
        else $display("FAIL drain: got %0d pending blocks buffer_full=%0d expected 0 0", sbq.size(), bf);
        repeat (5) @(negedge clk);
    endtask

    function automatic logic [7:0] pat4(input int j);
        return 8'h80 | 8'(j & 127);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int    a;
        string s;
        rst_n = 1'b1; sel64 = 1'b0; mode = 2'd1; sha3_pad = 1'b1;
        din = '0; in_ready = 1'b0; is_last = 1'b0; bn = '0;

        // ---- Test 1: "Hello, world!" mode 1 SHA-3, reset state first ----
        do_reset();
        chk("reset_buffer_full", 64'(bf), 64'd0);
        chk("reset_out_last",    64'(ol), 64'd0);
        chk("reset_out_zero",    64'(ob == '0), 64'd1);
        eb = '0;
        s  = "Hello, world!";
        for (int i = 0; i < 13; i++) put_byte(i, s[i]);
        put_byte(13, 8'h06);
        put_byte(135, 8'h80);
        send32("Hell", 1'b0, 0, a);
        send32("o, w", 1'b0, 0, a);
        send32("orld", 1'b0, 0, a);
        send32("!xyz", 1'b1, 1, a);
        push_exp(1'b1, a + 30);
        end_msg();
        drain();

        // ---- Test 2: empty message, mode 3 Keccak ----
        mode = 2'd3; sha3_pad = 1'b0;
        do_reset();
        eb = '0;
        put_byte(0, 8'h01);
        put_byte(71, 8'h80);
        send32(32'h0, 1'b1, 0, a);
        push_exp(1'b1, a + 17);
        end_msg();
        drain();

        // ---- Test 3: 71 bytes, last word lands in the final slot ----
        mode = 2'd3; sha3_pad = 1'b1;
        do_reset();
        eb = '0;
        for (int j = 0; j < 71; j++) put_byte(j, 8'(j + 1));
        put_byte(71, 8'h86);
        for (int k = 0; k < 17; k++)
            send32({8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)}, 1'b0, 0, a);
        send32({8'd69, 8'd70, 8'd71, 8'hFF}, 1'b1, 3, a);
        push_exp(1'b1, a);
        end_msg();
        drain();

        // ---- Test 4: three blocks with a slow core ----
        mode = 2'd3; sha3_pad = 1'b1; ack_delay = 10;
        do_reset();
        eb = '0;
        for (int j = 0; j < 72; j++) put_byte(j, pat4(j));
        push_exp(1'b0, -1);
        eb = '0;
        for (int j = 0; j < 72; j++) put_byte(j, pat4(72 + j));
        push_exp(1'b0, -1);
        for (int k = 0; k < 40; k++)
            send32({pat4(4*k), pat4(4*k+1), pat4(4*k+2), pat4(4*k+3)}, 1'b0, 0, a);
        send32(32'hA5A5A5A5, 1'b1, 0, a);
        eb = '0;
        for (int j = 0; j < 16; j++) put_byte(j, pat4(144 + j));
        put_byte(16, 8'h06);
        put_byte(71, 8'h80);
        push_exp(1'b1, a + 13);
        end_msg();
        drain();
        ack_delay = 0;

        // ---- Test 5: asynchronous reset while padding ----
        mode = 2'd3; sha3_pad = 1'b0;
        do_reset();
        send32("abcX", 1'b1, 3, a);
        #3 rst_n = 1'b0;
        #1;
        chk("midpad_reset_buffer_full", 64'(bf), 64'd0);
        chk("midpad_reset_out_last",    64'(ol), 64'd0);
        chk("midpad_reset_out_zero",    64'(ob == '0), 64'd1);
        @(negedge clk);
        in_ready = 1'b0; is_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // New message at mode 2; mode/sha3_pad change after the first word
        // must not affect it.
        mode = 2'd2; sha3_pad = 1'b1;
        eb = '0;
        s  = "ABCDEF";
        for (int i = 0; i < 6; i++) put_byte(i, s[i]);
        put_byte(6, 8'h06);
        put_byte(103, 8'h80);
        send32("ABCD", 1'b0, 0, a);
        mode = 2'd0; sha3_pad = 1'b0;
        send32("EFgh", 1'b1, 2, a);
        push_exp(1'b1, a + 24);
        end_msg();
        drain();

        // ---- Test 6: 64-bit words, mode 0 SHA-3 ----
        sel64 = 1'b1; mode = 2'd0; sha3_pad = 1'b1;
        do_reset();
        eb = '0;
        s  = "1234567890";
        for (int i = 0; i < 10; i++) put_byte(i, s[i]);
        put_byte(10, 8'h06);
        put_byte(143, 8'h80);
        send("12345678", 1'b0, 0, a);
        send({"90", 48'hFFFF_FFFF_FFFF}, 1'b1, 2, a);
        push_exp(1'b1, a + 16);
        end_msg();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
